ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/ram_port_arbiter_if.sv | 43 ++++
 rtl/ram_port_arbiter_rr_pick.sv | 35 +++
 rtl/ram_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared defaults and port-select encoding for the RAM port arbiter
package ram_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 8;

  // Which physical RAM port a granted access was steered to.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and dual-port RAM bus bundle for the arbiter
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);

  // Requester side
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [NREQ*DW-1:0] rdata;

  // RAM side
  logic [AW-1:0]      ram_addr_a;
  logic [AW-1:0]      ram_addr_b;
  logic [DW-1:0]      ram_data_a;
  logic [DW-1:0]      ram_data_b;
  logic               ram_wr_a;
  logic               ram_wr_b;
  logic [DW-1:0]      ram_q_a;
  logic [DW-1:0]      ram_q_b;

  // Arbiter view
  modport slave (
    input  req, we, addr, wdata, ram_q_a, ram_q_b,
    output gnt, rvalid, rdata,
    output ram_addr_a, ram_addr_b, ram_data_a, ram_data_b, ram_wr_a, ram_wr_b
  );

  // Requesters plus RAM model view
  modport master (
    output req, we, addr, wdata, ram_q_a, ram_q_b,
    input  gnt, rvalid, rdata,
    input  ram_addr_a, ram_addr_b, ram_data_a, ram_data_b, ram_wr_a, ram_wr_b
  );

endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// rtl/ram_port_arbiter_rr_pick.sv - rotating first-set search with optional excluded index
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] mask_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            excl_en_i,
  input  logic [IW-1:0]   excl_i,
  output logic            found_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk the mask starting at ptr_i, wrapping at NREQ, and keep the first hit.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum  = {1'b0, ptr_i} + (IW+1)'(k);
      cand = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
      if (!found_o && mask_i[cand] && !(excl_en_i && (cand == excl_i))) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter mapping NREQ requesters onto a dual-port RAM
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  ram_port_arbiter_if.slave   bus,
  output logic [7:0]          conflict_cnt_o
);

  localparam int IW = $clog2(NREQ);

  // Who owns each RAM port's read data on the following cycle.
  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
    port_e         port;
  } own_t;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (v == IW'(NREQ - 1)) ? '0 : v + IW'(1);
  endfunction

  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  own_t               own_a_q, own_a_d, own_b_q, own_b_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NREQ*DW-1:0] rdata_q, rdata_d;

  logic               found_a, found_b;
  logic [IW-1:0]      idx_a, idx_b, ptr_b;
  logic [AW-1:0]      addr_a_c, addr_b_c;
  logic [DW-1:0]      wdata_a_c, wdata_b_c;
  logic               we_a_c, we_b_c;
  logic               collide, grant_a, grant_b;

  assign ptr_b = inc_wrap(idx_a);

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_a (
    .mask_i    (bus.req),
    .ptr_i     (rr_ptr_q),
    .excl_en_i (1'b0),
    .excl_i    ('0),
    .found_o   (found_a),
    .idx_o     (idx_a)
  );

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick_b (
    .mask_i    (bus.req),
    .ptr_i     (ptr_b),
    .excl_en_i (found_a),
    .excl_i    (idx_a),
    .found_o   (found_b),
    .idx_o     (idx_b)
  );

  // Fetch both candidates' operands and decide whether port B must defer.
  always_comb begin
    addr_a_c  = bus.addr[idx_a*AW +: AW];
    addr_b_c  = bus.addr[idx_b*AW +: AW];
    wdata_a_c = bus.wdata[idx_a*DW +: DW];
    wdata_b_c = bus.wdata[idx_b*DW +: DW];
    we_a_c    = bus.we[idx_a];
    we_b_c    = bus.we[idx_b];
    collide   = found_a && found_b && (addr_a_c == addr_b_c) && (we_a_c || we_b_c);
    grant_a   = found_a && !reset;
    grant_b   = found_b && !collide && !reset;
  end

  // Drive grants and both RAM ports; an idle port is held at all zeros.
  always_comb begin
    bus.gnt        = '0;
    bus.ram_addr_a = '0;
    bus.ram_data_a = '0;
    bus.ram_wr_a   = 1'b0;
    bus.ram_addr_b = '0;
    bus.ram_data_b = '0;
    bus.ram_wr_b   = 1'b0;
    if (grant_a) begin
      bus.gnt[idx_a] = 1'b1;
      bus.ram_addr_a = addr_a_c;
      bus.ram_data_a = we_a_c ? wdata_a_c : '0;
      bus.ram_wr_a   = we_a_c;
    end
    if (grant_b) begin
      bus.gnt[idx_b] = 1'b1;
      bus.ram_addr_b = addr_b_c;
      bus.ram_data_b = we_b_c ? wdata_b_c : '0;
      bus.ram_wr_b   = we_b_c;
    end
  end

  // Next pointer, port ownership for granted reads, and the collision counter.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    own_a_d  = '0;
    own_b_d  = '0;
    cnt_d    = cnt_q;
    if (grant_b) begin
      rr_ptr_d = inc_wrap(idx_b);
    end else if (grant_a) begin
      rr_ptr_d = inc_wrap(idx_a);
    end
    if (grant_a && !we_a_c) begin
      own_a_d = '{valid: 1'b1, idx: idx_a, port: PORT_A};
    end
    if (grant_b && !we_b_c) begin
      own_b_d = '{valid: 1'b1, idx: idx_b, port: PORT_B};
    end
    if (collide && !reset && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Route last cycle's RAM read data back to its owner; other slices hold.
  always_comb begin
    bus.rvalid = '0;
    rdata_d    = rdata_q;
    if (!reset && own_a_q.valid) begin
      bus.rvalid[own_a_q.idx] = 1'b1;
      rdata_d[own_a_q.idx*DW +: DW] = (own_a_q.port == PORT_A) ? bus.ram_q_a : bus.ram_q_b;
    end
    if (!reset && own_b_q.valid) begin
      bus.rvalid[own_b_q.idx] = 1'b1;
      rdata_d[own_b_q.idx*DW +: DW] = (own_b_q.port == PORT_A) ? bus.ram_q_a : bus.ram_q_b;
    end
    bus.rdata = rdata_d;
  end

  assign conflict_cnt_o = cnt_q;

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      own_a_q  <= '0;
      own_b_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      own_a_q  <= own_a_d;
      own_b_q  <= own_b_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] cnt;
  logic       mem_init;
  logic [7:0] mem [32];
  int         n_cmp;
  int         n_err;

  ram_port_arbiter_if #(.NREQ(4), .AW(5), .DW(8)) bus ();

  ram_port_arbiter #(.NREQ(4), .AW(5), .DW(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .conflict_cnt_o (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port RAM with registered read, old data on same-edge read/write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 32; k++) mem[k] <= 8'h40 + 8'(k);
    end else begin
      if (bus.ram_wr_a) mem[bus.ram_addr_a] <= bus.ram_data_a;
      if (bus.ram_wr_b) mem[bus.ram_addr_b] <= bus.ram_data_b;
    end
    bus.ram_q_a <= mem[bus.ram_addr_a];
    bus.ram_q_b <= mem[bus.ram_addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_reqs();
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [4:0] a, input logic [7:0] d);
    bus.req[i]         = 1'b1;
    bus.we[i]          = w;
    bus.addr[i*5 +: 5] = a;
    bus.wdata[i*8 +: 8] = d;
  endtask

  task automatic drop(input int i);
    bus.req[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    mem_init = 1'b1;
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i), 8'hEE);
    @(posedge clk);
    #1;
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_gnt",    32'(bus.gnt), 32'h0);
    chk("rst_wr_a",   32'(bus.ram_wr_a), 32'h0);
    chk("rst_wr_b",   32'(bus.ram_wr_b), 32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_rdata",  bus.rdata, 32'h0);
    chk("rst_cnt",    32'(cnt), 32'h0);
    tick();
    reset = 1'b0;
    clear_reqs();

    // Write then read-back through a different requester
    set_req(0, 1'b1, 5'd3, 8'hA5);
    @(negedge clk);
    chk("wr_gnt",    32'(bus.gnt), 32'h1);
    chk("wr_wr_a",   32'(bus.ram_wr_a), 32'h1);
    chk("wr_addr_a", 32'(bus.ram_addr_a), 32'h3);
    chk("wr_data_a", 32'(bus.ram_data_a), 32'hA5);
    chk("wr_idle_b", 32'({bus.ram_wr_b, bus.ram_addr_b, bus.ram_data_b}), 32'h0);
    tick();
    drop(0);
    set_req(1, 1'b0, 5'd3, 8'h00);
    @(negedge clk);
    chk("rd_gnt",    32'(bus.gnt), 32'h2);
    chk("rd_addr_a", 32'(bus.ram_addr_a), 32'h3);
    chk("rd_wr_a",   32'(bus.ram_wr_a), 32'h0);
    tick();
    drop(1);
    @(negedge clk);
    chk("rd_rvalid", 32'(bus.rvalid), 32'h2);
    chk("rd_rdata1", 32'(bus.rdata[15:8]), 32'hA5);
    tick();
    @(negedge clk);
    chk("hold_rvalid", 32'(bus.rvalid), 32'h0);
    chk("hold_rdata1", 32'(bus.rdata[15:8]), 32'hA5);
    tick();

    // Four readers, two grants per cycle
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 5'(i), 8'h00);
    @(negedge clk);
    chk("rr4_gnt1",   32'(bus.gnt), 32'h3);
    chk("rr4_addr_a", 32'(bus.ram_addr_a), 32'h0);
    chk("rr4_addr_b", 32'(bus.ram_addr_b), 32'h1);
    tick();
    drop(0);
    drop(1);
    @(negedge clk);
    chk("rr4_gnt2",   32'(bus.gnt), 32'hC);
    chk("rr4_addr_a2", 32'(bus.ram_addr_a), 32'h2);
    chk("rr4_addr_b2", 32'(bus.ram_addr_b), 32'h3);
    chk("rr4_rv1",    32'(bus.rvalid), 32'h3);
    chk("rr4_rdata1", bus.rdata, 32'h0000_4140);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("rr4_rv2",    32'(bus.rvalid), 32'hC);
    chk("rr4_rdata2", bus.rdata, 32'hA542_4140);
    tick();

    // Write-write collision on one address
    do_reset();
    set_req(0, 1'b1, 5'd7, 8'h11);
    set_req(1, 1'b1, 5'd7, 8'h22);
    @(negedge clk);
    chk("ww_gnt1",  32'(bus.gnt), 32'h1);
    chk("ww_cnt0",  32'(cnt), 32'h0);
    chk("ww_data1", 32'(bus.ram_data_a), 32'h11);
    chk("ww_wr_b",  32'(bus.ram_wr_b), 32'h0);
    tick();
    drop(0);
    @(negedge clk);
    chk("ww_gnt2",  32'(bus.gnt), 32'h2);
    chk("ww_cnt1",  32'(cnt), 32'h1);
    chk("ww_data2", 32'(bus.ram_data_a), 32'h22);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("ww_cnt_end", 32'(cnt), 32'h1);
    chk("ww_mem7",    32'(mem[7]), 32'h22);
    tick();

    // Read/write collision from rr_ptr=2, then mixed non-colliding pairs
    do_reset();
    set_req(1, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    chk("rw_pre_gnt", 32'(bus.gnt), 32'h2);
    tick();
    drop(1);
    set_req(2, 1'b0, 5'd9, 8'h00);
    set_req(3, 1'b1, 5'd9, 8'h5C);
    @(negedge clk);
    chk("rw_gnt1",   32'(bus.gnt), 32'h4);
    chk("rw_addr_a", 32'(bus.ram_addr_a), 32'h9);
    chk("rw_wr_a",   32'(bus.ram_wr_a), 32'h0);
    chk("rw_cnt0",   32'(cnt), 32'h0);
    chk("rw_rv_pre", 32'(bus.rvalid), 32'h2);
    chk("rw_rd_pre", 32'(bus.rdata[15:8]), 32'h40);
    tick();
    drop(2);
    @(negedge clk);
    chk("rw_gnt2",   32'(bus.gnt), 32'h8);
    chk("rw_wr_a2",  32'(bus.ram_wr_a), 32'h1);
    chk("rw_data_a", 32'(bus.ram_data_a), 32'h5C);
    chk("rw_cnt1",   32'(cnt), 32'h1);
    chk("rw_rv2",    32'(bus.rvalid), 32'h4);
    chk("rw_rdata2", 32'(bus.rdata[23:16]), 32'h49);
    tick();
    clear_reqs();
    set_req(0, 1'b1, 5'd10, 8'h77);
    set_req(1, 1'b0, 5'd11, 8'h00);
    @(negedge clk);
    chk("mix_gnt",    32'(bus.gnt), 32'h3);
    chk("mix_wr_a",   32'(bus.ram_wr_a), 32'h1);
    chk("mix_addr_a", 32'(bus.ram_addr_a), 32'hA);
    chk("mix_wr_b",   32'(bus.ram_wr_b), 32'h0);
    chk("mix_addr_b", 32'(bus.ram_addr_b), 32'hB);
    chk("mix_cnt",    32'(cnt), 32'h1);
    tick();
    clear_reqs();
    set_req(2, 1'b0, 5'd5, 8'h00);
    set_req(3, 1'b0, 5'd5, 8'h00);
    @(negedge clk);
    chk("rr_same_gnt", 32'(bus.gnt), 32'hC);
    chk("rr_same_b",   32'(bus.ram_addr_b), 32'h5);
    chk("rr_same_cnt", 32'(cnt), 32'h1);
    chk("mix_rv",      32'(bus.rvalid), 32'h2);
    chk("mix_rdata",   32'(bus.rdata[15:8]), 32'h4B);
    tick();
    clear_reqs();
    @(negedge clk);
    chk("rr_same_rv",    32'(bus.rvalid), 32'hC);
    chk("rr_same_rdata", 32'(bus.rdata[31:16]), 32'h4545);
    tick();

    // Reset right after a read grant squashes its rvalid
    do_reset();
    set_req(0, 1'b0, 5'd0, 8'h00);
    @(negedge clk);
    chk("rs_gnt", 32'(bus.gnt), 32'h1);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 5'(i), 8'h99);
    @(negedge clk);
    chk("rs_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rs_gnt0",   32'(bus.gnt), 32'h0);
    chk("rs_wr",     32'({bus.ram_wr_a, bus.ram_wr_b}), 32'h0);
    tick();
    reset = 1'b0;
    bus.we = '0;
    @(negedge clk);
    chk("rs_ptr0",   32'(bus.gnt), 32'h3);
    chk("rs_cnt",    32'(cnt), 32'h0);
    chk("rs_rv_off", 32'(bus.rvalid), 32'h0);
    tick();

    // Saturating collision counter
    do_reset();
    set_req(0, 1'b1, 5'd7, 8'h01);
    set_req(1, 1'b1, 5'd7, 8'h02);
    for (int k = 1; k <= 260; k++) begin
      tick();
      if (k == 254) chk("sat_254", 32'(cnt), 32'd254);
      if (k == 255) chk("sat_255", 32'(cnt), 32'd255);
    end
    chk("sat_260", 32'(cnt), 32'd255);
    clear_reqs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
